// File: rtl/clint_timer.sv
`default_nettype none
// ============================================================================
// Module      : clint_timer
// Description : Core-local interruptor timer block. Provides a 64-bit mtime
//               counter, one 64-bit mtimecmp and one msip bit per hart, a
//               two-state register-bus responder, and per-hart timer/software
//               interrupt levels with single-cycle falling-edge pulses.
//               Optional macro CLINT_PRESCALER_EN: when defined, mtime
//               advances once every PRESCALE clocks; otherwise every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module clint_timer #(
    parameter int NUM_HARTS = 1,
    parameter int PRESCALE  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [15:0]          addr,
    input  logic                 ren,
    input  logic                 wen,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 error,
    output logic [63:0]          mtime,
    output logic [NUM_HARTS-1:0] timer_int,
    output logic [NUM_HARTS-1:0] soft_int,
    output logic [NUM_HARTS-1:0] timer_int_clear,
    output logic [NUM_HARTS-1:0] soft_int_clear
);

    // Bus FSM encoding
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    // mtime lives at 0xBFF8/0xBFFC, i.e. 64-bit word index 0x17FF
    localparam logic [12:0] c_MTIME_DWORD = 13'h17FF;

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [31:0]          r_rdata;
    logic                 r_error;
    logic [63:0]          r_mtime;
    logic [63:0]          r_mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] r_msip;
    logic [NUM_HARTS-1:0] r_soft_clr;
    logic [NUM_HARTS-1:0] r_timer_int;
    logic [NUM_HARTS-1:0] r_timer_clr;

    logic [NUM_HARTS-1:0] w_msip_sel;
    logic [NUM_HARTS-1:0] w_cmp_sel;
    logic [NUM_HARTS-1:0] w_cmp_hit;
    logic                 w_mtime_sel;
    logic                 w_mapped;
    logic                 w_capture;
    logic                 w_wr;
    logic                 w_mtime_wr;
    logic [31:0]          w_rd_val;
    logic                 w_tick;
    logic [1:0]           w_unused_addr;

    // Byte-lane bits carry no meaning: every register is a 32-bit word
    assign w_unused_addr = addr[1:0];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart_decode
        assign w_msip_sel[h] = (addr[15:14] == 2'b00) && (addr[13:2] == 12'(h));
        assign w_cmp_sel[h]  = (addr[15:14] == 2'b01) && (addr[13:3] == 11'(h));
        assign w_cmp_hit[h]  = (r_mtime >= r_mtimecmp[h]);
    end

    assign w_mtime_sel = (addr[15:3] == c_MTIME_DWORD);
    assign w_mapped    = (|w_msip_sel) || (|w_cmp_sel) || w_mtime_sel;

    // A request is taken on the IDLE->RESP edge; writes to holes are dropped
    assign w_capture  = (r_state == S_IDLE) && (ren || wen);
    assign w_wr       = w_capture && wen && w_mapped;
    assign w_mtime_wr = w_wr && w_mtime_sel;

    // Read mux over pre-write register values
    always_comb begin
        w_rd_val = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_msip_sel[h]) begin
                w_rd_val = {31'b0, r_msip[h]};
            end
            if (w_cmp_sel[h]) begin
                w_rd_val = addr[2] ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
            end
        end
        if (w_mtime_sel) begin
            w_rd_val = addr[2] ? r_mtime[63:32] : r_mtime[31:0];
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: every accepted request gets exactly one RESP cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (ren || wen) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs: busy while a request waits in IDLE, response shown only in RESP;
    // a reset landing in RESP suppresses the response so the access is abandoned
    always_comb begin
        busy  = 1'b0;
        rdata = '0;
        error = 1'b0;
        if (r_state == S_IDLE) begin
            busy = ren || wen;
        end else if (!RST) begin
            rdata = r_rdata;
            error = r_error;
        end
    end

    // Response capture; combined read+write returns the pre-write value
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdata <= '0;
            r_error <= 1'b0;
        end else if (w_capture) begin
            r_error <= !w_mapped;
            r_rdata <= (ren && w_mapped) ? w_rd_val : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
`ifdef CLINT_PRESCALER_EN
    localparam logic [7:0] c_PRESC_LAST = 8'(PRESCALE - 1);

    logic [7:0] r_presc;

    assign w_tick = (r_presc == c_PRESC_LAST);

    // Prescale counter; restarts whenever software rewrites mtime
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc <= '0;
        end else if (w_mtime_wr || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end
`else
    logic [7:0] w_unused_prescale;

    assign w_unused_prescale = 8'(PRESCALE);
    assign w_tick            = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Timer state
    // ------------------------------------------------------------------

    // mtime: a bus write wins over the tick, touching only the addressed half
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mtime <= '0;
        end else if (w_mtime_wr) begin
            if (addr[2]) begin
                r_mtime[63:32] <= wdata;
            end else begin
                r_mtime[31:0] <= wdata;
            end
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // Per-hart compare registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_mtimecmp[h] <= '1;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_wr && w_cmp_sel[h]) begin
                    if (addr[2]) begin
                        r_mtimecmp[h][63:32] <= wdata;
                    end else begin
                        r_mtimecmp[h][31:0] <= wdata;
                    end
                end
            end
        end
    end

    // Software interrupt bits and their 1->0 pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_msip     <= '0;
            r_soft_clr <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_soft_clr[h] <= 1'b0;
                if (w_wr && w_msip_sel[h]) begin
                    r_msip[h]     <= wdata[0];
                    r_soft_clr[h] <= r_msip[h] & ~wdata[0];
                end
            end
        end
    end

    // Timer interrupt levels from registered compare, plus falling-edge pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer_int <= '0;
            r_timer_clr <= '0;
        end else begin
            r_timer_int <= w_cmp_hit;
            r_timer_clr <= r_timer_int & ~w_cmp_hit;
        end
    end

    assign mtime           = r_mtime;
    assign timer_int       = r_timer_int;
    assign soft_int        = r_msip;
    assign timer_int_clear = r_timer_clr;
    assign soft_int_clear  = r_soft_clr;

endmodule
`default_nettype wire

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, meaning the number of harts served (1..8).
REQ-002 SHALL have parameter PRESCALE, default 1, meaning CLK cycles per mtime tick (1..255).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port addr, input, 16 bits: byte offset into the register window; bits [1:0] are ignored.
REQ-006 SHALL have port ren, input, 1 bit: read request.
REQ-007 SHALL have port wen, input, 1 bit: write request.
REQ-008 SHALL have port wdata, input, 32 bits: write data.
REQ-009 SHALL have port rdata, output, 32 bits: read data.
REQ-010 SHALL have port busy, output, 1 bit: the request is not yet complete.
REQ-011 SHALL have port error, output, 1 bit: the completing access hit an unmapped address.
REQ-012 SHALL have port mtime, output, 64 bits: current machine time.
REQ-013 SHALL have ports timer_int, soft_int, timer_int_clear and soft_int_clear, each an output of NUM_HARTS bits, with one bit per hart.

Function
REQ-014 The address map SHALL be:
  - msip[h] at 0x0000+4h; only bit 0 is implemented and the other bits read 0.
  - mtimecmp[h] low half at 0x4000+8h, high half at 0x4004+8h.
  - mtime low half at 0xBFF8, high half at 0xBFFC.
  - Every other offset is unmapped.
REQ-015 The bus FSM SHALL have two states, IDLE and RESP.
  - IDLE with (ren|wen): busy=1 combinationally, request captured, next state RESP.
  - RESP: busy=0, rdata and error valid for exactly this cycle, next state IDLE.
REQ-016 A write SHALL commit to the register on the IDLE->RESP edge; a read SHALL return the value sampled on that same edge.
REQ-017 When ren and wen are both high, the access SHALL be treated as a write, and rdata SHALL return the pre-write value.
REQ-018 Requests presented while in RESP SHALL be ignored; the requester holds them until busy is seen low in IDLE.
REQ-019 An unmapped access SHALL assert error in RESP, return rdata=0, and modify no state.
REQ-020 rdata SHALL be 0 whenever the FSM is not in RESP.
REQ-021 mtime SHALL increment by 1, wrapping from 2^64-1 to 0, on each tick.
REQ-022 A bus write to either half of mtime SHALL take priority over a same-cycle tick: the written half takes wdata, the other half holds, and no increment occurs that cycle.
REQ-023 timer_int[h] SHALL be registered: 1 when mtime >= mtimecmp[h] (unsigned 64-bit), evaluated on post-update values, so it asserts 1 cycle after the condition first holds.
REQ-024 soft_int[h] SHALL equal msip[h].
REQ-025 timer_int_clear[h] SHALL pulse high for 1 cycle when timer_int[h] falls.
REQ-026 soft_int_clear[h] SHALL pulse high for 1 cycle when msip[h] goes from 1 to 0.
REQ-027 Writing 1 to an msip[h] that is already 1 SHALL produce no pulse.
REQ-028 Accesses to hart indices >= NUM_HARTS SHALL be unmapped.

Reset
REQ-029 While RST is high at a clock edge, the block SHALL reset to:
  - mtime=0
  - every mtimecmp=0xFFFF_FFFF_FFFF_FFFF
  - msip=0
  - prescale counter=0
  - FSM=IDLE
  - all pulse and interrupt outputs=0
REQ-030 A reset arriving in RESP SHALL abandon the access: no rdata or error is produced and the requester re-issues it.
REQ-031 The first tick after RST is released SHALL occur PRESCALE cycles later.

Configuration
REQ-032 The macro CLINT_PRESCALER_EN SHALL control tick generation.
  - Defined: an 8-bit counter counts 0..PRESCALE-1; the tick fires when the counter equals PRESCALE-1, and the counter then wraps to 0.
  - Undefined: PRESCALE is ignored, no counter exists, and every CLK cycle is a tick.
REQ-033 A bus write to mtime SHALL reset the prescale counter to 0.

Verification
REQ-034 The bench SHALL check reset behaviour: after reset, read 0xBFF8 then 0x4000 -> 0x0000_0000 then 0xFFFF_FFFF; timer_int=0, soft_int=0, error=0.
REQ-035 The bench SHALL check timer interrupt timing, with PRESCALE=1 and the macro undefined:
  - Stimulus: write mtimecmp[0]=0x0000_0000_0000_0020 (high half then low half), then write mtime low=0x10.
  - Response: timer_int[0] rises exactly 17 cycles after the mtime write commits.
REQ-036 The bench SHALL check interrupt clearing with timer_int[0]=1:
  - Writing mtimecmp[0] high=0xFFFF_FFFF makes timer_int[0] fall.
  - timer_int_clear[0] is high for exactly 1 cycle.
REQ-037 The bench SHALL check software interrupts:
  - Write msip[0]=1 -> soft_int[0]=1.
  - Write 1 again -> no pulse.
  - Write 0 -> soft_int[0]=0 and a single-cycle soft_int_clear[0].
REQ-038 The bench SHALL check the wrap case: write mtime = low 0xFFFF_FFFF, high 0xFFFF_FFFF; after the next tick, mtime=0.
REQ-039 The bench SHALL check the unmapped case: read 0x2000 -> error=1 in RESP and rdata=0; a write 0xDEAD_BEEF to 0x0004 with NUM_HARTS=1 -> error=1 and no state change.
REQ-040 The bench SHALL check mid-access reset: assert RST during RESP -> the next cycle shows busy=0 and error=0, and all registers hold their reset values.
